// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

  // Operand forwarding selects for the EX-stage ALU inputs
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // resultSrc encoding of a load instruction
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Hard-wired zero register; never a real producer
  localparam logic [4:0] REG_X0 = 5'd0;

  // Pick the youngest in-flight producer of rs; MEM is younger than WB so it wins.
  function automatic logic [1:0] fwd_sel(
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    if (reg_write_m && (rd_m != REG_X0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (reg_write_w && (rd_w != REG_X0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Reset beats clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: load-use stall,
// control-redirect flush, EX operand forwarding and perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int         CNT_W           = 32,
  parameter logic [1:0] LOAD_RESULT_SRC = RESULT_SRC_LOAD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic [1:0]       resultSrcE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             pcSrcE,
  input  logic             cntClr,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [CNT_W-1:0] cycleCnt,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  logic lw_stall;
  logic stall_event;

  // A load in EX whose destination is read by the ID instruction; x0 never counts.
  assign lw_stall = (resultSrcE == LOAD_RESULT_SRC) &&
                    (rdE != REG_X0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  // A redirect squashes the ID instruction anyway, so the stall is moot then.
  assign stall_event = lw_stall && !pcSrcE;

  // Stall/flush/forward decode; reset forces bubbles and no forwarding.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else begin
      if (pcSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (lw_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      forwardAE = fwd_sel(regWriteM, rdM, regWriteW, rdW, rs1E);
      forwardBE = fwd_sel(regWriteM, rdM, regWriteW, rdW, rs2E);
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cntClr),
    .inc   (1'b1),
    .count (cycleCnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cntClr),
    .inc   (stall_event),
    .count (stallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cntClr),
    .inc   (pcSrcE),
    .count (flushCnt)
  );

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Drives the flush/stall inputs of the IF/ID and ID/EX pipeline registers, including flushE into id_ex.
- Drives the EX-stage operand forwarding selects.
- Keeps saturating performance counters (cycles, load-use stalls, control redirects) readable by the debug/trace logic.

Parameters:
- CNT_W, 32, width of each performance counter.
- LOAD_RESULT_SRC, 2'b01, resultSrcE encoding that marks a load in EX.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous active-high reset; sampled on posedge clk.
- rs1D  in  5  source reg 1 of the instruction in ID.
- rs2D  in  5  source reg 2 of the instruction in ID.
- rs1E  in  5  source reg 1 in EX.
- rs2E  in  5  source reg 2 in EX.
- rdE  in  5  destination reg in EX.
- rdM  in  5  destination reg in MEM.
- rdW  in  5  destination reg in WB.
- resultSrcE  in  2  result select of the EX instruction.
- regWriteM  in  1  MEM instruction writes the register file.
- regWriteW  in  1  WB instruction writes the register file.
- pcSrcE  in  1  taken branch or jump resolved in EX.
- cntClr  in  1  synchronous clear of all counters.
- stallF  out  1  hold PC.
- stallD  out  1  hold the IF/ID register.
- flushD  out  1  bubble the IF/ID register.
- flushE  out  1  bubble the ID/EX register.
- forwardAE  out  2  ALU operand A select.
- forwardBE  out  2  ALU operand B select.
- cycleCnt  out  CNT_W  cycles since reset/clear.
- stallCnt  out  CNT_W  load-use stall cycles.
- flushCnt  out  CNT_W  control redirect events.

Behaviour:
- Control outputs (stall/flush/forward) are combinational from the current inputs, with zero latency. Counters are registered and update on posedge clk.
- lwStall condition:
  - (resultSrcE == LOAD_RESULT_SRC), and
  - rdE != 0, and
  - (rdE == rs1D or rdE == rs2D).
- Redirect: pcSrcE = 1.
- Priority between the two:
  - Redirect has priority over lwStall. When both are asserted: stallF = stallD = 0, flushD = flushE = 1.
  - lwStall alone: stallF = stallD = flushE = 1, flushD = 0.
  - pcSrcE alone: flushD = flushE = 1, stalls = 0.
- forwardAE (forwardBE identical using rs2E):
  - 2'b10 if regWriteM and rdM != 0 and rdM == rs1E.
  - Else 2'b01 if regWriteW and rdW != 0 and rdW == rs1E.
  - Else 2'b00.
  - MEM has priority over WB when both match.
- x0 never triggers forwarding or stall.
- While reset = 1:
  - flushD = flushE = 1.
  - stallF = stallD = 0.
  - forwardAE = forwardBE = 2'b00.
  - All counters load 0 at the clock edge.
- Counters: each is a CNT_W-bit saturating up-counter; at all-ones it holds its value.
  - cycleCnt increments every non-reset cycle.
  - stallCnt increments on cycles where lwStall is asserted and not overridden by redirect.
  - flushCnt increments on cycles with pcSrcE = 1.
  - An increment is visible on the cycle after the event.
- Counter precedence (highest first): reset, then cntClr, then increment. cntClr and an event in the same cycle leave the counter at 0.
- Reset mid-stall: the stall drops in the reset cycle, and counters clear.
- The block has no FSM beyond the counters. Stall duration is inherently one cycle, because the ID/EX bubble removes the load dependency on the next cycle.

Decomposition:
- hazard_pkg holds:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - RESULT_SRC_LOAD = 2'b01.
  - REG_X0 = 5'd0.
- Sub-module sat_counter (params W; ports clk, reset, clr, inc, count) is instantiated three times.

Test Plan:
- Reset: reset = 1 for 2 cycles with pcSrcE = 0 -> flushD = flushE = 1, stalls = 0, all counters read 0 after release. Then 5 idle cycles -> cycleCnt = 5.
- Load-use: resultSrcE = 01, rdE = 5, rs1D = 5 -> stallF = stallD = flushE = 1, flushD = 0. Next cycle stallCnt = 1. Repeat with rdE = 0 -> no stall.
- Forwarding priority: regWriteM = regWriteW = 1, rdM = rdW = 7, rs1E = 7, rs2E = 7 -> forwardAE = forwardBE = 10. Then rdM = 3 -> both become 01. Then rdW = 0 -> both become 00.
- Redirect beats stall: pcSrcE = 1 together with the load-use condition -> flushD = flushE = 1, stallF = stallD = 0. flushCnt increments to 1 and stallCnt is unchanged.
- Counter clear and saturation:
  - CNT_W = 4: run 20 cycles -> cycleCnt holds at 15.
  - cntClr = 1 in the same cycle as pcSrcE = 1 -> flushCnt = 0 and cycleCnt = 0 next cycle.
- Mid-stall reset: assert reset during the load-use condition -> stall outputs drop that cycle and all counters read 0 next cycle.
